// File: rtl/steer_pwm.sv
// steer_pwm: servo steering output stage. Clamps a Q3.13 heading, scales it to a pulse
// width, slew-limits the width once per frame and drives the servo PWM with a stale failsafe.
module steer_pwm #(
  parameter int FRAME_CYCLES   = 1000000,
  parameter int CENTER_CYCLES  = 75000,
  parameter int SCALE          = 31830,
  parameter int MAX_ANGLE      = 6434,
  parameter int MAX_STEP       = 5000,
  parameter int TIMEOUT_FRAMES = 10,
  parameter int CNT_W          = 20
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic signed [15:0]  angle_in,
  input  logic                angle_valid,
  output logic                pwm_out,
  output logic                frame_start,
  output logic [CNT_W-1:0]    width_cur,
  output logic                stale
);

  localparam int MISS_W = $clog2(TIMEOUT_FRAMES + 1);

  localparam logic [CNT_W-1:0]        FRAME_LAST = CNT_W'(FRAME_CYCLES - 1);
  localparam logic [CNT_W-1:0]        CENTER_U   = CNT_W'(CENTER_CYCLES);
  localparam logic [CNT_W-1:0]        STEP_U     = CNT_W'(MAX_STEP);
  localparam logic [CNT_W-1:0]        CNT_ONE    = CNT_W'(1);
  localparam logic signed [CNT_W+1:0] STEP_S     = (CNT_W+2)'(MAX_STEP);
  localparam logic signed [15:0]      ANG_MAX    = 16'(MAX_ANGLE);
  localparam logic signed [15:0]      ANG_MIN    = 16'(-MAX_ANGLE);
  localparam logic signed [31:0]      SCALE_S    = 32'(SCALE);
  localparam logic [MISS_W-1:0]       MISS_LAST  = MISS_W'(TIMEOUT_FRAMES - 1);
  localparam logic [MISS_W-1:0]       MISS_MAX   = MISS_W'(TIMEOUT_FRAMES);
  localparam logic [MISS_W-1:0]       MISS_ONE   = MISS_W'(1);

  typedef enum logic [0:0] {
    ST_RUN      = 1'b0,
    ST_FAILSAFE = 1'b1
  } state_t;

  state_t                    state_r, state_nxt_s;
  logic                      stale_r;
  logic                      force_center_s;
  logic [CNT_W-1:0]          cnt_r;
  logic                      wrap_s;
  logic signed [15:0]        ang_r, ang_clamp_s;
  logic signed [31:0]        ang_ext_s, prod_s;
  logic [CNT_W-1:0]          target_r, target_nxt_s;
  logic [CNT_W-1:0]          width_r, width_nxt_s;
  logic signed [CNT_W+1:0]   diff_s;
  logic                      pwm_r, frame_start_r;
  logic [MISS_W-1:0]         miss_r, miss_nxt_s;
  logic                      seen_r, seen_any_s;

  assign wrap_s     = (cnt_r == FRAME_LAST);
  assign seen_any_s = seen_r | angle_valid;
  assign ang_ext_s  = {{16{ang_r[15]}}, ang_r};
  assign prod_s     = ang_ext_s * SCALE_S;

  // Frame counter: 0..FRAME_CYCLES-1, wrapping to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_r <= '0;
    else if (wrap_s) cnt_r <= '0;
    else cnt_r <= cnt_r + CNT_ONE;
  end

  // Clamp the incoming angle to the steering range.
  always_comb begin
    ang_clamp_s = angle_in;
    if (angle_in > ANG_MAX) ang_clamp_s = ANG_MAX;
    else if (angle_in < ANG_MIN) ang_clamp_s = ANG_MIN;
    else ang_clamp_s = angle_in;
  end

  // Angle sample register; the latest valid sample wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ang_r <= '0;
    else if (angle_valid) ang_r <= ang_clamp_s;
    else ang_r <= ang_r;
  end

  // Target width: centre plus floored scaled offset, or centre while stale.
  always_comb begin
    target_nxt_s = CENTER_U;
    if (force_center_s) target_nxt_s = CENTER_U;
    else target_nxt_s = CENTER_U + CNT_W'(prod_s >>> 13);
  end

  // Target register follows the sampled angle one edge later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) target_r <= CENTER_U;
    else target_r <= target_nxt_s;
  end

  // Slew limiter: difference taken two bits wider so the sign survives.
  always_comb begin
    diff_s      = $signed({2'b00, target_r}) - $signed({2'b00, width_r});
    width_nxt_s = target_r;
    if (diff_s > STEP_S) width_nxt_s = width_r + STEP_U;
    else if (diff_s < -STEP_S) width_nxt_s = width_r - STEP_U;
    else width_nxt_s = target_r;
  end

  // Width and waveform registers; width only moves on the wrap edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      width_r       <= CENTER_U;
      pwm_r         <= 1'b0;
      frame_start_r <= 1'b0;
    end else begin
      width_r       <= wrap_s ? width_nxt_s : width_r;
      pwm_r         <= (cnt_r < width_r);
      frame_start_r <= wrap_s;
    end
  end

  // Miss counter: a valid in FAILSAFE clears it, otherwise it is settled at each wrap.
  always_comb begin
    miss_nxt_s = miss_r;
    if (state_r == ST_FAILSAFE && angle_valid) miss_nxt_s = '0;
    else if (wrap_s) begin
      if (seen_any_s) miss_nxt_s = '0;
      else if (miss_r < MISS_MAX) miss_nxt_s = miss_r + MISS_ONE;
      else miss_nxt_s = miss_r;
    end else miss_nxt_s = miss_r;
  end

  // Per-frame valid tracking; a valid on the wrap edge belongs to the ending frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miss_r <= '0;
      seen_r <= 1'b0;
    end else begin
      miss_r <= miss_nxt_s;
      if (wrap_s) seen_r <= 1'b0;
      else if (angle_valid) seen_r <= 1'b1;
      else seen_r <= seen_r;
    end
  end

  // FSM state register; stale is registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_FAILSAFE;
      stale_r <= 1'b1;
    end else begin
      state_r <= state_nxt_s;
      stale_r <= (state_nxt_s == ST_FAILSAFE);
    end
  end

  // FSM next state.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_RUN: begin
        if (wrap_s && !seen_any_s && (miss_r >= MISS_LAST)) state_nxt_s = ST_FAILSAFE;
        else state_nxt_s = ST_RUN;
      end
      ST_FAILSAFE: begin
        if (angle_valid) state_nxt_s = ST_RUN;
        else state_nxt_s = ST_FAILSAFE;
      end
      default: state_nxt_s = ST_FAILSAFE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    force_center_s = 1'b1;
    case (state_r)
      ST_RUN:      force_center_s = 1'b0;
      ST_FAILSAFE: force_center_s = 1'b1;
      default:     force_center_s = 1'b1;
    endcase
  end

  assign pwm_out     = pwm_r;
  assign frame_start = frame_start_r;
  assign width_cur   = width_r;
  assign stale       = stale_r;

endmodule

// File: tb/tb_steer_pwm.sv
// Directed bench for steer_pwm: a scaled-down servo instance (A) for slew/clamp/timeout
// and a small-frame instance (B) for frame-boundary and latest-sample cases.
module tb_steer_pwm;

  localparam int A_FRAME = 1000, A_CENTER = 750, A_SCALE = 318, A_MAXA = 6434;
  localparam int A_STEP = 50, A_TO = 3, A_W = 12;
  localparam int B_FRAME = 400, B_CENTER = 150, B_SCALE = 8192, B_MAXA = 6434;
  localparam int B_STEP = 1000, B_TO = 10, B_W = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic signed [15:0] ang_a, ang_b;
  logic val_a, val_b;
  logic pwm_a, pwm_b, fs_a, fs_b, st_a, st_b;
  logic [A_W-1:0] w_a;
  logic [B_W-1:0] w_b;

  steer_pwm #(.FRAME_CYCLES(A_FRAME), .CENTER_CYCLES(A_CENTER), .SCALE(A_SCALE),
              .MAX_ANGLE(A_MAXA), .MAX_STEP(A_STEP), .TIMEOUT_FRAMES(A_TO), .CNT_W(A_W))
    dut_a (.clk(clk), .rst_n(rst_n), .angle_in(ang_a), .angle_valid(val_a),
           .pwm_out(pwm_a), .frame_start(fs_a), .width_cur(w_a), .stale(st_a));

  steer_pwm #(.FRAME_CYCLES(B_FRAME), .CENTER_CYCLES(B_CENTER), .SCALE(B_SCALE),
              .MAX_ANGLE(B_MAXA), .MAX_STEP(B_STEP), .TIMEOUT_FRAMES(B_TO), .CNT_W(B_W))
    dut_b (.clk(clk), .rst_n(rst_n), .angle_in(ang_b), .angle_valid(val_b),
           .pwm_out(pwm_b), .frame_start(fs_b), .width_cur(w_b), .stale(st_b));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Advance to the next negedge where frame_start is high.
  task automatic wait_fs(input bit sel, input string name);
    bit got;
    int lim;
    got = 1'b0;
    lim = sel ? B_FRAME + 20 : A_FRAME + 20;
    for (int i = 0; i < lim && !got; i++) begin
      @(negedge clk);
      got = sel ? fs_b : fs_a;
    end
    if (!got) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: no frame_start within %0d cycles", name, lim);
    end
  endtask

  // From a frame_start negedge, count cycles and pwm-high cycles up to the next one.
  task automatic measure(input bit sel, input string name, input int exp_hi, input int exp_per);
    int n, hi, lim;
    bit got;
    n = 0; hi = 0; got = 1'b0;
    lim = sel ? B_FRAME + 20 : A_FRAME + 20;
    while (!got && n < lim) begin
      @(negedge clk);
      n++;
      if (sel ? pwm_b : pwm_a) hi++;
      got = sel ? fs_b : fs_a;
    end
    check({name, " period"}, 32'(n), 32'(exp_per));
    check({name, " pulse"}, 32'(hi), 32'(exp_hi));
  endtask

  typedef struct {
    logic               valid;
    logic signed [15:0] angle;
    int                 width;
    logic               stale;
  } vec_t;

  vec_t tab [27];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // one record per frame: optional mid-frame valid, then width/stale after the wrap
    tab[0]  = '{1'b1,  16'sd6434,  800, 1'b0};
    tab[1]  = '{1'b1,  16'sd6434,  850, 1'b0};
    tab[2]  = '{1'b1,  16'sd6434,  900, 1'b0};
    tab[3]  = '{1'b1,  16'sd6434,  950, 1'b0};
    tab[4]  = '{1'b1,  16'sd6434,  999, 1'b0};
    tab[5]  = '{1'b1,  16'sd6434,  999, 1'b0};
    tab[6]  = '{1'b1,  16'sd8000,  999, 1'b0};
    tab[7]  = '{1'b1, -16'sd6434,  949, 1'b0};
    tab[8]  = '{1'b1, -16'sd6434,  899, 1'b0};
    tab[9]  = '{1'b1, -16'sd6434,  849, 1'b0};
    tab[10] = '{1'b1, -16'sd6434,  799, 1'b0};
    tab[11] = '{1'b1, -16'sd6434,  749, 1'b0};
    tab[12] = '{1'b1, -16'sd6434,  699, 1'b0};
    tab[13] = '{1'b1, -16'sd6434,  649, 1'b0};
    tab[14] = '{1'b1, -16'sd6434,  599, 1'b0};
    tab[15] = '{1'b1, -16'sd6434,  549, 1'b0};
    tab[16] = '{1'b1, -16'sd6434,  500, 1'b0};
    tab[17] = '{1'b1, -16'sd6434,  500, 1'b0};
    tab[18] = '{1'b0,  16'sd0,     500, 1'b0};
    tab[19] = '{1'b0,  16'sd0,     500, 1'b0};
    tab[20] = '{1'b0,  16'sd0,     500, 1'b1};
    tab[21] = '{1'b0,  16'sd0,     550, 1'b1};
    tab[22] = '{1'b0,  16'sd0,     600, 1'b1};
    tab[23] = '{1'b0,  16'sd0,     650, 1'b1};
    tab[24] = '{1'b0,  16'sd0,     700, 1'b1};
    tab[25] = '{1'b0,  16'sd0,     750, 1'b1};
    tab[26] = '{1'b0,  16'sd0,     750, 1'b1};

    rst_n = 1'b0;
    ang_a = '0; val_a = 1'b0;
    ang_b = '0; val_b = 1'b0;
    repeat (3) @(negedge clk);
    check("reset pwm", 32'(pwm_a), 32'd0);
    check("reset frame_start", 32'(fs_a), 32'd0);
    check("reset width", 32'(w_a), 32'(A_CENTER));
    check("reset stale", 32'(st_a), 32'd1);
    rst_n = 1'b1;

    n = 0;
    while (!fs_a && n < A_FRAME + 20) begin
      @(negedge clk);
      n++;
    end
    check("first frame_start delay", 32'(n), 32'(A_FRAME));
    measure(1'b0, "a first frame", A_CENTER, A_FRAME);

    for (int i = 0; i < 27; i++) begin
      repeat (10) @(negedge clk);
      if (tab[i].valid) begin
        ang_a = tab[i].angle;
        val_a = 1'b1;
        @(negedge clk);
        val_a = 1'b0;
      end
      wait_fs(1'b0, $sformatf("vec%0d", i));
      check($sformatf("vec%0d width", i), 32'(w_a), 32'(tab[i].width));
      check($sformatf("vec%0d stale", i), 32'(st_a), 32'(tab[i].stale));
    end

    // a valid while stale leaves FAILSAFE on the very next edge
    repeat (5) @(negedge clk);
    check("stale before valid", 32'(st_a), 32'd1);
    ang_a = 16'sd0;
    val_a = 1'b1;
    @(posedge clk);
    #1;
    check("stale cleared next edge", 32'(st_a), 32'd0);
    @(negedge clk);
    val_a = 1'b0;

    // B: valid on the edge before the wrap must not affect that wrap's step
    wait_fs(1'b1, "b sync");
    repeat (B_FRAME - 2) @(negedge clk);
    ang_b = 16'sd100;
    val_b = 1'b1;
    @(negedge clk);
    val_b = 1'b0;
    @(negedge clk);
    check("b wrap frame_start", 32'(fs_b), 32'd1);
    check("b wrap uses old target", 32'(w_b), 32'(B_CENTER));
    wait_fs(1'b1, "b next wrap");
    check("b next wrap width", 32'(w_b), 32'd250);
    check("b stale after valid", 32'(st_b), 32'd0);

    // B: two samples in one frame, the later one sets the width
    repeat (20) @(negedge clk);
    ang_b = 16'sd100;
    val_b = 1'b1;
    @(negedge clk);
    val_b = 1'b0;
    repeat (20) @(negedge clk);
    ang_b = -16'sd100;
    val_b = 1'b1;
    @(negedge clk);
    val_b = 1'b0;
    wait_fs(1'b1, "b latest wrap");
    check("b latest wins width", 32'(w_b), 32'd50);
    measure(1'b1, "b latest frame", 50, B_FRAME);

    // B: asynchronous reset in the middle of a pulse
    repeat (20) @(negedge clk);
    check("b mid pulse high", 32'(pwm_b), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("b async reset pwm", 32'(pwm_b), 32'd0);
    check("b async reset stale", 32'(st_b), 32'd1);
    check("b async reset width", 32'(w_b), 32'(B_CENTER));
    check("b async reset frame_start", 32'(fs_b), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
